// File: rtl/fifo_burst_reader.sv
// ============================================================================
// Module      : fifo_burst_reader
// Description : Pops a programmed burst of words from a show-ahead FIFO and
//               streams them downstream via a 2-entry valid/ready buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module fifo_burst_reader #(
  parameter int  WIDTH   = 8,
  parameter int  MAX_LEN = 16,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  output logic             busy,
  output logic             done,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_read_data,
  output logic             fifo_pop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [1:0]         occ_q, occ_d;
  logic [WIDTH-1:0]   data0_q, data0_d, data1_q, data1_d;
  logic               last0_q, last0_d, last1_q, last1_d;
  logic               done_q, done_d;
  logic               do_pop;
  logic               do_hs;

  // Pop depends only on registers and fifo_empty, never on out_ready.
  assign do_pop = (state_q == S_RUN) && (remaining_q != '0) && !fifo_empty
                  && (occ_q != 2'd2);
  assign do_hs  = (occ_q != 2'd0) && out_ready;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (burst_len == '0) begin
            done_d = 1'b1;
          end else begin
            remaining_d = (burst_len > MAX_LEN_C) ? MAX_LEN_C : burst_len;
            state_d     = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (do_pop) begin
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (do_hs && last0_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Entry 0 is the head; a pop lands in the first slot free after any handshake.
  always_comb begin
    data0_d = data0_q;
    data1_d = data1_q;
    last0_d = last0_q;
    last1_d = last1_q;
    occ_d   = occ_q;
    if (do_hs) begin
      data0_d = data1_q;
      last0_d = last1_q;
    end
    if (do_pop) begin
      if ((occ_q == 2'd0) || ((occ_q == 2'd1) && do_hs)) begin
        data0_d = fifo_read_data;
        last0_d = (remaining_q == LEN_W'(1));
      end else begin
        data1_d = fifo_read_data;
        last1_d = (remaining_q == LEN_W'(1));
      end
    end
    case ({do_pop, do_hs})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      occ_q       <= 2'd0;
      data0_q     <= '0;
      data1_q     <= '0;
      last0_q     <= 1'b0;
      last1_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      occ_q       <= occ_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      last0_q     <= last0_d;
      last1_q     <= last1_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign fifo_pop  = do_pop;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = data0_q;
  assign out_last  = (occ_q != 2'd0) && last0_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
// ============================================================================
// Module      : tb_fifo_burst_reader
// Description : Self-checking bench: FIFO model plus stream-order scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fifo_burst_reader;

  localparam int WIDTH   = 8;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] burst_len;
  logic             busy, done, fifo_pop, out_valid, out_last;
  logic             fifo_empty, out_ready;
  logic [WIDTH-1:0] fifo_read_data, out_data;

  always #5 clk = ~clk;

  fifo_burst_reader #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .burst_len(burst_len),
    .busy(busy), .done(done), .fifo_empty(fifo_empty),
    .fifo_read_data(fifo_read_data), .fifo_pop(fifo_pop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last)
  );

  typedef struct {
    int len;
    int preload;
    int ready_pct;
    int push_pct;
    int exp_words;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] fq[$];          // FIFO contents
  logic [WIDTH-1:0] exp_stream[$];  // words still owed to the output stream
  bit  m_busy, m_done;
  int  n_exp, n_pops, n_hs, last_burst_hs;
  bit  prev_stall;
  logic [WIDTH-1:0] prev_data;
  logic prev_last;
  bit  done_seen;
  int  ready_pct = 100;
  int  push_pct  = 0;

  logic s_pop, s_valid, s_last, s_done, s_busy, s_empty, s_ready, s_start;
  logic [WIDTH-1:0] s_data;
  int   s_len;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endfunction

  task automatic fifo_sync();
    fifo_empty     = (fq.size() == 0);
    fifo_read_data = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    fq.push_back(w);
    exp_stream.push_back(w);
    fifo_sync();
  endtask

  function automatic void model_reset();
    m_busy     = 1'b0;
    m_done     = 1'b0;
    n_exp      = 0;
    n_pops     = 0;
    n_hs       = 0;
    prev_stall = 1'b0;
    exp_stream = fq;
  endfunction

  // Sample and check at negedge, then advance FIFO and reference model after posedge.
  task automatic cycle();
    bit next_busy, next_done;
    int lenc;
    @(negedge clk);
    s_pop = fifo_pop; s_valid = out_valid; s_data = out_data; s_last = out_last;
    s_done = done; s_busy = busy; s_empty = fifo_empty; s_ready = out_ready;
    s_start = start; s_len = int'(burst_len);
    next_busy = m_busy;
    next_done = 1'b0;
    if (rst_n) begin
      chk("done", s_done, m_done);
      chk("busy", s_busy, m_busy);
      chk("pop_while_empty", s_pop && s_empty, 0);
      chk("pop_outside_burst", s_pop && !m_busy, 0);
      if (prev_stall) begin
        chk("stall_valid", s_valid, 1);
        chk("stall_data", s_data, prev_data);
        chk("stall_last", s_last, prev_last);
      end
      if (s_pop) begin
        chk("pop_with_full_buffer", (n_pops - n_hs) < 2, 1);
        n_pops++;
        chk("pop_count_bound", n_pops <= n_exp, 1);
      end
      if (s_valid && s_ready) begin
        chk("hs_in_burst", m_busy, 1);
        chk("stream_nonempty", exp_stream.size() > 0, 1);
        if (exp_stream.size() > 0) begin
          chk("out_data", s_data, exp_stream[0]);
          void'(exp_stream.pop_front());
        end
        chk("out_last", s_last, (n_hs + 1) == n_exp);
        n_hs++;
        if (n_hs == n_exp) begin
          chk("pops_in_burst", n_pops, n_exp);
          next_busy     = 1'b0;
          next_done     = 1'b1;
          last_burst_hs = n_hs;
        end
      end
      if (s_start && !m_busy) begin
        lenc   = (s_len > MAX_LEN) ? MAX_LEN : s_len;
        n_exp  = lenc;
        n_pops = 0;
        n_hs   = 0;
        if (lenc == 0) begin
          next_done     = 1'b1;
          last_burst_hs = 0;
        end else begin
          next_busy = 1'b1;
        end
      end
      prev_stall = s_valid && !s_ready;
      prev_data  = s_data;
      prev_last  = s_last;
    end else begin
      chk("rst_valid", s_valid, 0);
      chk("rst_pop", s_pop, 0);
      chk("rst_busy", s_busy, 0);
      chk("rst_done", s_done, 0);
    end
    if (s_done) done_seen = 1'b1;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (s_pop && fq.size() > 0) void'(fq.pop_front());
      m_busy = next_busy;
      m_done = next_done;
    end
    fifo_sync();
  endtask

  task automatic start_burst(input int len);
    done_seen = 1'b0;
    start     = 1'b1;
    burst_len = LEN_W'(len);
    cycle();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_words);
    int k;
    k = 0;
    while (!done_seen && k < 300) begin
      out_ready = ($urandom_range(0, 99) < ready_pct);
      if ($urandom_range(0, 99) < push_pct) push(WIDTH'($urandom_range(0, 255)));
      cycle();
      k++;
    end
    chk({name, "_done_seen"}, done_seen, 1);
    if (done_seen) chk({name, "_words"}, last_burst_hs, exp_words);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    logic [7:0] pop_v, val_v, last_v, done_v;
    logic [WIDTH-1:0] data_h[8];
    logic [WIDTH-1:0] t1_words[4];
    int p;

    vecs[0] = '{len: 5,  preload: 5,  ready_pct: 100, push_pct: 0,  exp_words: 5};
    vecs[1] = '{len: 3,  preload: 0,  ready_pct: 70,  push_pct: 40, exp_words: 3};
    vecs[2] = '{len: 19, preload: 20, ready_pct: 100, push_pct: 0,  exp_words: 16};
    vecs[3] = '{len: 31, preload: 4,  ready_pct: 50,  push_pct: 30, exp_words: 16};
    vecs[4] = '{len: 1,  preload: 2,  ready_pct: 30,  push_pct: 0,  exp_words: 1};
    vecs[5] = '{len: 0,  preload: 0,  ready_pct: 50,  push_pct: 0,  exp_words: 0};
    vecs[6] = '{len: 16, preload: 8,  ready_pct: 60,  push_pct: 50, exp_words: 16};
    vecs[7] = '{len: 10, preload: 12, ready_pct: 20,  push_pct: 0,  exp_words: 10};
    t1_words[0] = 8'h11; t1_words[1] = 8'h22; t1_words[2] = 8'h33; t1_words[3] = 8'h44;

    rst_n = 1'b0; start = 1'b0; burst_len = '0; out_ready = 1'b0;
    fifo_sync();
    model_reset();
    last_burst_hs = 0;
    done_seen = 1'b0;
    #2;
    chk("reset_out_data", out_data, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_out_valid", out_valid, 0);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // Burst of 4 at full throughput: exact cycle timing
    for (int i = 0; i < 4; i++) push(t1_words[i]);
    out_ready = 1'b1;
    start_burst(4);
    for (int i = 0; i < 8; i++) begin
      cycle();
      pop_v[i] = s_pop; val_v[i] = s_valid; last_v[i] = s_last; done_v[i] = s_done;
      data_h[i] = s_data;
    end
    chk("t1_pop_pattern", pop_v, 8'b0000_1111);
    chk("t1_valid_pattern", val_v, 8'b0001_1110);
    chk("t1_last_pattern", last_v, 8'b0001_0000);
    chk("t1_done_pattern", done_v, 8'b0010_0000);
    for (int i = 0; i < 4; i++) chk("t1_data", data_h[i+1], t1_words[i]);
    chk("t1_fifo_left", fq.size(), 0);

    // Downstream blocked: only two words popped ahead
    for (int i = 0; i < 6; i++) push(WIDTH'(8'hA0 + i));
    out_ready = 1'b0;
    start_burst(6);
    p = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      p += int'(s_pop);
    end
    chk("t2_pops_while_blocked", p, 2);
    chk("t2_head_word", out_data, 8'hA0);
    ready_pct = 100; push_pct = 0;
    wait_done("t2", 6);

    // FIFO runs dry mid-burst, then refills
    push(8'h31);
    out_ready = 1'b1;
    start_burst(3);
    p = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      p += int'(s_pop);
    end
    chk("t3_pops_before_refill", p, 1);
    push(8'h32);
    push(8'h33);
    wait_done("t3", 3);

    // Zero-length burst
    start_burst(0);
    cycle();
    chk("t4_done", s_done, 1);
    chk("t4_busy", s_busy, 0);
    chk("t4_pop", s_pop, 0);

    // Start ignored mid-burst; start in the done cycle chains without a gap
    for (int i = 0; i < 10; i++) push(WIDTH'(8'h50 + i));
    out_ready = 1'b1;
    start_burst(5);
    cycle();
    start = 1'b1; burst_len = LEN_W'(2);
    cycle();
    start = 1'b0;
    p = 0;
    while (!done && p < 50) begin
      cycle();
      p++;
    end
    chk("t5_done_reached", done, 1);
    chk("t5_first_words", last_burst_hs, 5);
    start = 1'b1; burst_len = LEN_W'(3);
    cycle();
    done_seen = 1'b0;
    start = 1'b0;
    cycle();
    chk("t5_busy_no_gap", s_busy, 1);
    chk("t5_pop_no_gap", s_pop, 1);
    wait_done("t5_second", 3);

    // Asynchronous reset with a full output buffer
    for (int i = 0; i < 8; i++) push(WIDTH'(8'hC0 + i));
    out_ready = 1'b0;
    start_burst(8);
    for (int i = 0; i < 4; i++) cycle();
    chk("t6_pops_ahead", n_pops, 2);
    chk("t6_valid_before_reset", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid_async", out_valid, 0);
    chk("t6_busy_async", busy, 0);
    chk("t6_pop_async", fifo_pop, 0);
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
    out_ready = 1'b1;
    cycle();
    cycle();
    ready_pct = 100; push_pct = 0;
    start_burst(3);
    wait_done("t6_after_reset", 3);

    // Randomized table-driven bursts
    foreach (vecs[v]) begin
      for (int i = 0; i < vecs[v].preload; i++) push(WIDTH'($urandom_range(0, 255)));
      ready_pct = vecs[v].ready_pct;
      push_pct  = vecs[v].push_pct;
      out_ready = ($urandom_range(0, 99) < ready_pct);
      start_burst(vecs[v].len);
      wait_done($sformatf("vec%0d", v), vecs[v].exp_words);
      out_ready = 1'b1;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Consumer-side controller for the team's push/pop FIFOs with registered empty/full.
- On a start command it pops a programmed number of words from the FIFO read port.
- It presents those words downstream on a valid/ready stream and marks the final word with out_last.
- A 2-entry output buffer gives full throughput with no combinational path from out_ready to fifo_pop.

Parameters:
width, 8, data word width (must match the FIFO width)
max_len, 16, maximum burst length; len_w = $clog2(max_len + 1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  command strobe; sampled only in IDLE
burst_len  input  len_w  number of words for this burst; sampled with start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse at burst completion
fifo_empty  input  1  FIFO registered empty flag
fifo_read_data  input  width  FIFO head word (show-ahead: valid whenever !fifo_empty)
fifo_pop  output  1  pop request to FIFO; must never be high while fifo_empty
out_valid  output  1  downstream data valid
out_ready  input  1  downstream ready
out_data  output  width  downstream data
out_last  output  1  high with the final word of the burst

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low. All state is cleared on rst_n low, regardless of clk.
- Reset values:
  - state = IDLE
  - busy = 0, done = 0, fifo_pop = 0
  - out_valid = 0, out_last = 0, out_data = 0
  - remaining = 0, buffer occupancy = 0
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 and burst_len>0: latch remaining = min(burst_len, max_len); go to RUN next cycle.
  - start=1 and burst_len=0: stay in IDLE; done pulses the next cycle; no pops.
  - start while busy: ignored; no queuing.
- RUN pop rule:
  - fifo_pop = (state==RUN) && remaining!=0 && !fifo_empty && occ!=2.
  - occ is the registered output-buffer occupancy (0..2).
  - fifo_pop is a function of registers and fifo_empty only.
- Capture:
  - In a pop cycle, fifo_read_data is written into the buffer on that same clock edge.
  - The word appears on out_data with out_valid=1 no earlier than the following cycle. Latency from pop to out_valid is 1 cycle.
  - remaining decrements on each pop.
  - A word is tagged last when it is popped with remaining==1.
- Transition to DRAIN: when the pop with remaining==1 occurs, the next state is DRAIN.
- Output buffer:
  - Strict FIFO order; the head entry drives out_data and out_last; out_valid = (occ!=0).
  - A handshake is out_valid && out_ready; it removes the head entry.
  - Pop and handshake in the same cycle: occ is unchanged.
  - While out_valid=1 and out_ready=0, out_data and out_last must stay stable.
- Throughput: with fifo_empty=0 and out_ready held at 1, one word per cycle after the initial 1-cycle latency.
- DRAIN:
  - No pops.
  - When the handshake on the out_last word occurs, go to IDLE next cycle and pulse done=1 for exactly that one cycle.
  - busy falls in the same cycle that done rises.
- fifo_empty mid-burst: pops stall and already-buffered words keep draining; pops resume when fifo_empty=0.
- out_ready=0 mid-burst: at most 2 words are popped ahead, then fifo_pop holds at 0.
- Back-to-back bursts: start accepted in the cycle done=1 (state is IDLE), so there is no dead cycle beyond done.
- Arithmetic: burst_len>max_len saturates to max_len. remaining never underflows. occ never exceeds 2 or goes below 0.
- Reset mid-burst:
  - Immediate return to reset values; buffered words are discarded.
  - Words already popped are lost; no done pulse.

Test Plan:
1. burst_len=4, FIFO preloaded 0x11,0x22,0x33,0x44, out_ready=1 → fifo_pop high 4 consecutive cycles; out_data 11,22,33,44 on consecutive cycles starting 1 cycle after the first pop; out_last only with 0x44; done 1 cycle after the 0x44 handshake; FIFO empty afterwards.
2. burst_len=6, out_ready=0 for 5 cycles then 1 → exactly 2 pops then fifo_pop=0; out_data holds the first word stable; after release all 6 words arrive in order, last on the 6th, then done.
3. burst_len=3, FIFO holds 1 word with 2 more pushed 4 cycles later → fifo_pop never high while fifo_empty=1; 3 words delivered in order; out_last on the 3rd.
4. burst_len=0 → done pulses the next cycle; busy never rises; no fifo_pop. burst_len=max_len+3 (when representable in len_w) → exactly max_len words delivered.
5. start pulsed again mid-burst with burst_len=2 → ignored; original burst count is delivered. New start in the done cycle → second burst begins without a gap.
6. rst_n driven low asynchronously mid-RUN with occ=2 → out_valid, busy and fifo_pop go 0 immediately; no done; a fresh burst after release works normally.
